// File: rtl/alu_iter_if.sv
// Request/response bundle for the iterative ALU.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both request and response channels.
interface alu_iter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic [2:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] z;
  logic        equal;
  logic        overflow;
  logic        zero;

  // Requester side: issues operations and takes results.
  modport master (
    output in_valid, x, y, op, out_ready,
    input  in_ready, out_valid, z, equal, overflow, zero
  );

  // ALU side: accepts operations and presents results.
  modport slave (
    input  in_valid, x, y, op, out_ready,
    output in_ready, out_valid, z, equal, overflow, zero
  );
endinterface

// File: rtl/alu_iter.sv
// Iterative 32-bit ALU: logic/arith in one cycle, shifts one bit per cycle.
// Latency: result visible 1 cycle after accept (non-shift), 1+shamt cycles for shifts.
// Backpressure: one transaction in flight; result held until out_ready, no request taken meanwhile.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_iter_if.slave bus
);

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRA = 3'd7;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [4:0]       count;
  logic [WIDTH-1:0] z_q;
  logic             equal_q;
  logic             overflow_q;
  logic             zero_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic [WIDTH-1:0] z_shift;

  // Handshake readiness is a pure decode of the state register.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.z         = z_q;
  assign bus.equal     = equal_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

  // Single-cycle result for the incoming request; shifts just load x.
  always_comb begin
    sum     = bus.x + bus.y;
    diff    = bus.x - bus.y;
    res     = bus.x;
    res_ovf = 1'b0;
    case (bus.op)
      ALU_AND: res = bus.x & bus.y;
      ALU_OR:  res = bus.x | bus.y;
      ALU_ADD: begin
        res     = sum;
        res_ovf = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (sum[WIDTH-1] != bus.x[WIDTH-1]);
      end
      ALU_SUB: begin
        res     = diff;
        res_ovf = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (diff[WIDTH-1] != bus.x[WIDTH-1]);
      end
      // Signed compare directly, so the answer is right even when x-y overflows.
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(bus.x) < $signed(bus.y))};
      default: res = bus.x;
    endcase
  end

  // One-bit step of the latched shift operation.
  always_comb begin
    z_shift = z_q;
    case (op_q)
      ALU_SRL: z_shift = {1'b0, z_q[WIDTH-1:1]};
      ALU_SLL: z_shift = {z_q[WIDTH-2:0], 1'b0};
      ALU_SRA: z_shift = {z_q[WIDTH-1], z_q[WIDTH-1:1]};
      default: z_shift = z_q;
    endcase
  end

  // Control FSM with registered result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= ALU_AND;
      count      <= 5'd0;
      z_q        <= '0;
      equal_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.op;
            equal_q    <= (bus.x == bus.y);
            overflow_q <= res_ovf;
            z_q        <= res;
            zero_q     <= (res == '0);
            count      <= bus.y[4:0];
            state      <= DONE;
            if ((bus.op == ALU_SRL || bus.op == ALU_SLL || bus.op == ALU_SRA) &&
                (bus.y[4:0] != 5'd0))
              state <= SHIFT;
          end
        end
        SHIFT: begin
          z_q    <= z_shift;
          zero_q <= (z_shift == '0);
          count  <= count - 5'd1;
          if (count == 5'd1)
            state <= DONE;
        end
        DONE: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: driver pushes expectations, monitor pops on responses.
// Latency: checks first-valid cycle against accept cycle plus shift amount.
// Backpressure: out_ready held low, high, or randomly toggled depending on phase.
module tb_alu_iter;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRA = 3'd7;

  typedef struct {
    logic [31:0] z;
    logic        eq;
    logic        ov;
    logic        zr;
    int          vcyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   rdy_mode;
  bit   head_seen;
  exp_t sb[$];

  alu_iter_if bus ();

  alu_iter #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model from the arithmetic definitions, using wide signed integers.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
    exp_t   e;
    longint sa;
    longint sb_;
    longint r;
    sa     = longint'($signed(a));
    sb_    = longint'($signed(b));
    e.ov   = 1'b0;
    e.vcyc = 0;
    e.z    = 32'd0;
    case (o)
      ALU_AND: e.z = a & b;
      ALU_OR:  e.z = a | b;
      ALU_ADD: begin
        r = sa + sb_;
        e.z = 32'(r);
        e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      ALU_SUB: begin
        r = sa - sb_;
        e.z = 32'(r);
        e.ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      ALU_SLT: e.z = (sa < sb_) ? 32'd1 : 32'd0;
      ALU_SRL: e.z = a >> b[4:0];
      ALU_SLL: e.z = a << b[4:0];
      default: e.z = 32'($signed(a) >>> b[4:0]);
    endcase
    e.eq = (a == b);
    e.zr = (e.z == 32'd0);
    return e;
  endfunction

  // Drive one request, wait (bounded) for acceptance, push the expectation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
                       input bit use_model, input logic [31:0] ez,
                       input logic eeq, input logic eov, input logic ezr);
    exp_t e;
    int   n;
    bit   ok;
    n  = 0;
    ok = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.x        = a;
    bus.y        = b;
    bus.op       = o;
    while (!ok) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      else if (++n > 500) break;
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (use_model) e = model(a, b, o);
      else begin
        e.z  = ez;
        e.eq = eeq;
        e.ov = eov;
        e.zr = ezr;
      end
      e.vcyc = cyc + 1 + (((o == ALU_SRL) || (o == ALU_SLL) || (o == ALU_SRA)) ? int'(b[4:0]) : 0);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.x        = $urandom;
    bus.y        = $urandom;
    bus.op       = 3'($urandom_range(0, 7));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  // Consumer-side ready generation.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare every presented response against the queue head.
  initial begin
    head_seen = 0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("stray_response", 32'd1, 32'd0);
        end else begin
          chk("z", bus.z, sb[0].z);
          chk("equal", 32'(bus.equal), 32'(sb[0].eq));
          chk("overflow", 32'(bus.overflow), 32'(sb[0].ov));
          chk("zero", 32'(bus.zero), 32'(sb[0].zr));
          chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
          if (!head_seen) chk("latency_cycle", 32'(cyc), 32'(sb[0].vcyc));
          head_seen = 1;
          if (bus.out_ready) begin
            void'(sb.pop_front());
            head_seen = 0;
          end
        end
      end
    end
  end

  initial begin
    cyc          = 0;
    checks       = 0;
    errors       = 0;
    rdy_mode     = 1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.x        = 32'd0;
    bus.y        = 32'd0;
    bus.op       = ALU_AND;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_z", bus.z, 32'd0);
    chk("rst_flags", {29'd0, bus.equal, bus.overflow, bus.zero}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a long arithmetic shift discards the transaction.
    issue(32'hF0000000, 32'd31, ALU_SRA, 0, 32'hFFFFFFFF, 0, 0, 0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    head_seen = 0;
    #1;
    chk("midshift_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midshift_rst_z", bus.z, 32'd0);
    chk("midshift_rst_flags", {29'd0, bus.equal, bus.overflow, bus.zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (40) @(negedge clk);

    // Directed cases with hand-derived results.
    issue(32'h7FFFFFFF, 32'h00000001, ALU_ADD, 0, 32'h80000000, 0, 1, 0);
    issue(32'h12345678, 32'h12345678, ALU_SUB, 0, 32'h00000000, 1, 0, 1);
    issue(32'h80000000, 32'h00000001, ALU_SUB, 0, 32'h7FFFFFFF, 0, 1, 0);
    issue(32'h80000000, 32'h00000001, ALU_SLT, 0, 32'h00000001, 0, 0, 0);
    issue(32'h00000001, 32'h80000000, ALU_SLT, 0, 32'h00000000, 0, 0, 1);
    issue(32'hF0000000, 32'h00000004, ALU_SRA, 0, 32'hFF000000, 0, 0, 0);
    issue(32'hF0000000, 32'h00000004, ALU_SRL, 0, 32'h0F000000, 0, 0, 0);
    issue(32'h00000001, 32'hFFFFFFFF, ALU_SLL, 0, 32'h80000000, 0, 0, 0);
    issue(32'hDEADBEEF, 32'h00000020, ALU_SRL, 0, 32'hDEADBEEF, 0, 0, 0);
    issue(32'h00F0000F, 32'h0F00F000, ALU_OR,  0, 32'h0FF0F00F, 0, 0, 0);
    drain("directed_drain");

    // Held response under backpressure; a competing request must be ignored.
    rdy_mode = 0;
    @(posedge clk);
    #1;
    issue(32'hFF00FF00, 32'h0F0F0F0F, ALU_AND, 0, 32'h0F000F00, 0, 0, 0);
    bus.in_valid = 1'b1;
    bus.x        = 32'h11111111;
    bus.y        = 32'h22222222;
    bus.op       = ALU_ADD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    rdy_mode = 1;
    drain("bp_drain");
    repeat (5) @(negedge clk);

    // Random operations with random request gaps and consumer stalls.
    rdy_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 7) == 0) a = 32'h7FFFFFFF ^ ($urandom_range(0, 1) ? 32'hFFFFFFFF : 32'h0);
      issue(a, b, 3'($urandom_range(0, 7)), 1, 32'd0, 0, 0, 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain("random_drain");
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
